pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
// PURPOSE
//   Parametrised pipeline stall/flush controller for the MIPS core in the AXI SoC.
//   Freezes pipeline stages from per-stage stall requests and sequences exception/ERET redirects.
//   Redirects are deferred while a memory bus transaction is outstanding.
//   Holds flush for a programmable number of cycles and keeps a saturating stall-cycle counter.
// PARAMETERS
//   NSTAGE       6             number of pipeline stages; width of stall request and stall masks
//   XLEN         32            width of cause, EPC and redirect PC
//   EXC_VECTOR   32'hBFC00380  redirect target for every non-ERET exception
//   ERET_CODE    32'h0000000E  cause code meaning ERET; target is EPC
//   FLUSH_CYCLES 1             cycles flush_o stays high per redirect (>=1)
//   CNT_W        32            stall-cycle counter width
// PORTS
//   clk              in   1       clock, rising edge
//   resetn           in   1       asynchronous reset, active low
//   stallreq_i       in   NSTAGE  per-stage stall request; bit k = stage k (0 = PC/IF)
//   excepttype_i     in   XLEN    exception cause from MEM stage; 0 = none
//   cp0_epc_i        in   XLEN    CP0 EPC value
//   bus_busy_i       in   1       data/instruction AXI transaction outstanding
//   stall_o          out  NSTAGE  per-stage stall; 1 = hold stage register
//   flush_o          out  1       flush all pipeline registers
//   new_pc_o         out  XLEN    redirect target
//   new_pc_valid_o   out  1       one-cycle pulse: PC must load new_pc_o
//   stall_cnt_o      out  CNT_W   cycles with any stall_o bit set, saturating
// BEHAVIOUR
//   Reset (resetn=0, async): state IDLE; stall_o=0, flush_o=0, new_pc_o=0, new_pc_valid_o=0, stall_cnt_o=0.
//   Stall mask (IDLE, no exception): k = highest set index of stallreq_i.
//     stall_o = bits [k:0] set, all others 0; stallreq_i=0 gives stall_o=0.
//     The stall mask is combinational, in the same cycle as the request.
//   FSM states: IDLE, WAIT_BUS, FLUSH.
//   IDLE, excepttype_i!=0: exception overrides all stall requests.
//     In the same cycle, stall_o = all ones and flush_o=0.
//     Latch the target: cp0_epc_i if cause==ERET_CODE, else EXC_VECTOR.
//     Next state: WAIT_BUS if bus_busy_i=1, else FLUSH.
//   WAIT_BUS: stall_o = all ones, flush_o=0; excepttype_i and stallreq_i are ignored.
//     Leave for FLUSH on the first cycle in which bus_busy_i=0.
//     The latched target is kept even if cp0_epc_i changes.
//   FLUSH: flush_o=1, stall_o=0, new_pc_o = latched target.
//     new_pc_valid_o=1 only in the first FLUSH cycle.
//     Stays exactly FLUSH_CYCLES cycles (down-counter), then returns to IDLE.
//     excepttype_i and stallreq_i are ignored.
//   Redirect latency: cause seen in cycle t with bus idle -> flush_o/new_pc_valid_o in t+1.
//     With the bus busy through cycle t+n -> flush in t+n+2.
//   Back-to-back: the IDLE cycle after FLUSH samples excepttype_i again.
//     A still-nonzero cause starts a new redirect.
//   new_pc_o holds its last value outside FLUSH; only FLUSH output is meaningful.
//   stall_cnt_o increments every cycle stall_o!=0, WAIT_BUS included.
//     It holds at all ones (2^CNT_W-1) and never wraps.
//   Reset asserted in any state aborts immediately: the pending redirect is lost and outputs go to reset values.
// TESTING
//   1. stallreq_i=6'b010000, no exception -> stall_o=6'b011111 same cycle; stall_cnt_o +1 per cycle.
//   2. stallreq_i=6'b000101 -> stall_o=6'b000111; stallreq_i=0 -> stall_o=0.
//   3. excepttype_i=0x08, bus_busy_i=0, stallreq_i=6'b111111 at t:
//      -> t: stall_o=all ones; t+1: flush_o=1, new_pc_valid_o=1, new_pc_o=0xBFC00380; t+2: IDLE.
//   4. excepttype_i=0x0E, cp0_epc_i=0x80001234, bus_busy_i=1 for 3 cycles; EPC changes during the wait:
//      -> stall_o=all ones for 4 cycles, then flush with new_pc_o=0x80001234.
//   5. FLUSH_CYCLES=3 -> flush_o high 3 cycles, new_pc_valid_o only in the first; exception during flush ignored.
//   6. resetn pulsed low in WAIT_BUS -> all outputs 0 asynchronously; no flush after release; CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush controller: per-stage stall masks from stall requests,
// exception/ERET redirect sequencing gated by bus activity, programmable flush
// length, and a saturating count of stalled cycles.
module pipe_ctrl_unit #(
  parameter int                NSTAGE       = 6,
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   EXC_VECTOR   = 32'hBFC00380,
  parameter logic [XLEN-1:0]   ERET_CODE    = 32'h0000000E,
  parameter int                FLUSH_CYCLES = 1,
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic [XLEN-1:0]   excepttype_i,
  input  logic [XLEN-1:0]   cp0_epc_i,
  input  logic              bus_busy_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [XLEN-1:0]   new_pc_o,
  output logic              new_pc_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUS, FLUSH} state_t;

  state_t            state;
  logic [XLEN-1:0]   target;
  logic [FCW-1:0]    fcnt;
  logic [NSTAGE-1:0] req_mask;
  logic              exc;
  logic [XLEN-1:0]   sel_tgt;

  // A stalled stage must also freeze every stage upstream of it, so each bit
  // is the OR of its own request and all requests further down the pipe.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_mask
    assign req_mask[k] = |stallreq_i[NSTAGE-1:k];
  end

  assign exc     = |excepttype_i;
  assign sel_tgt = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

  // Stall mask is combinational so a request freezes stages in the same cycle.
  always_comb begin
    stall_o = '0;
    case (state)
      IDLE:     stall_o = exc ? '1 : req_mask;
      WAIT_BUS: stall_o = '1;
      default:  stall_o = '0;
    endcase
  end

  // Redirect FSM; flush and PC outputs are registered so they line up with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      target         <= '0;
      fcnt           <= '0;
      flush_o        <= 1'b0;
      new_pc_o       <= '0;
      new_pc_valid_o <= 1'b0;
    end else begin
      new_pc_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (exc) begin
            target <= sel_tgt;
            if (bus_busy_i) begin
              state <= WAIT_BUS;
            end else begin
              state          <= FLUSH;
              flush_o        <= 1'b1;
              new_pc_o       <= sel_tgt;
              new_pc_valid_o <= 1'b1;
              fcnt           <= FCW'(FLUSH_CYCLES - 1);
            end
          end
        end
        WAIT_BUS: begin
          // Target was captured on entry; EPC changes while waiting are ignored.
          if (!bus_busy_i) begin
            state          <= FLUSH;
            flush_o        <= 1'b1;
            new_pc_o       <= target;
            new_pc_valid_o <= 1'b1;
            fcnt           <= FCW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state   <= IDLE;
            flush_o <= 1'b0;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any stage is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt_o <= '0;
    else if ((|stall_o) && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule
